// File: rtl/stat_resp_compactor.sv
`default_nettype none
// ============================================================================
// Module   : stat_resp_compactor
// Purpose  : 32-bit MISR that compacts a counted run of response vectors
//            into a single signature.
// Revision : 1.0 - initial release
// ============================================================================
module stat_resp_compactor #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter logic [31:0] SEED = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] vec_count,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        resp_ready,
    output logic        busy,
    output logic        done,
    output logic        sig_valid,
    output logic [31:0] sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_sig;
    logic [31:0] w_sig_next;
    logic [15:0] r_remain;
    logic [15:0] w_remain_next;
    logic        r_sig_valid;
    logic        w_sig_valid_next;
    logic        w_accept;
    logic [31:0] w_misr;

    assign w_accept = (r_state == RUN) && resp_valid;
    assign w_misr   = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ resp_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sig       <= SEED;
            r_remain    <= 16'd0;
            r_sig_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_sig       <= w_sig_next;
            r_remain    <= w_remain_next;
            r_sig_valid <= w_sig_valid_next;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_sig_next       = r_sig;
        w_remain_next    = r_remain;
        w_sig_valid_next = r_sig_valid;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sig_next       = SEED;
                    w_remain_next    = vec_count;
                    w_sig_valid_next = 1'b0;
                    w_next_state     = (vec_count != 16'd0) ? RUN : FIN;
                end
            end
            RUN: begin
                // RUN is only entered with a nonzero count, so remain never wraps.
                if (w_accept) begin
                    w_sig_next    = w_misr;
                    w_remain_next = r_remain - 16'd1;
                    if (r_remain == 16'd1) begin
                        w_next_state = FIN;
                    end
                end
            end
            FIN: begin
                w_sig_valid_next = 1'b1;
                w_next_state     = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign resp_ready = (r_state == RUN);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == FIN);
    assign sig_valid  = r_sig_valid;
    assign sig        = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_stat_resp_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_stat_resp_compactor
// Purpose  : Self-checking bench for stat_resp_compactor (vector table plus
//            hand-written corner sequences, scoreboard on done pulses).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stat_resp_compactor;

    localparam logic [31:0] C_POLY = 32'h04C11DB7;
    localparam logic [31:0] C_SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] vec_count;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        sig_valid;
    logic [31:0] sig;

    int tests     = 0;
    int fails     = 0;
    int acc_cnt   = 0;
    int done_cnt  = 0;
    logic [31:0] sb[$];

    typedef struct {
        int          n;
        logic [31:0] base;
        logic [31:0] step;
        logic [7:0]  mask;
        bit          rnd;
        bit          use_exp;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl[6];

    stat_resp_compactor #(.POLY(C_POLY), .SEED(C_SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_count  (vec_count),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .sig_valid  (sig_valid),
        .sig        (sig)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        logic [31:0] r;
        r = s << 1;
        if (s[31]) r = r ^ C_POLY;
        return r ^ d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_n && resp_valid && resp_ready) acc_cnt++;
    end

    // Every done pulse must match the oldest expected signature.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: got done=1 sig %h expected no done", sig);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                if (sig !== e) begin
                    fails++;
                    $display("FAIL done_sig: got %h expected %h", sig, e);
                end
            end
        end
    end

    task automatic run(input int n, input logic [31:0] base, input logic [31:0] step,
                       input logic [7:0] mask, input bit rnd, input bit use_exp,
                       input logic [31:0] expv);
        logic [31:0] m, d, prev, fin;
        int i, c;
        m = C_SEED;
        start = 1'b1;
        vec_count = n[15:0];
        tick();
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (n == 0) sb.push_back(use_exp ? expv : m);
        i = 0;
        c = 0;
        while (i < n) begin
            resp_valid = mask[c[2:0]];
            d = rnd ? $urandom : base + step * i;
            resp_data = d;
            check("ready_in_run", {31'd0, resp_ready}, 32'd1);
            if (resp_valid) begin
                m = misr(m, d);
                if (i == n - 1) sb.push_back(use_exp ? expv : m);
            end
            prev = sig;
            tick();
            if (resp_valid) begin
                i++;
                check("sig_step", sig, m);
            end else begin
                check("sig_hold", sig, prev);
            end
            c++;
        end
        resp_valid = 1'b0;
        fin = use_exp ? expv : m;
        check("done_latency", {31'd0, done}, 32'd1);
        check("ready_in_fin", {31'd0, resp_ready}, 32'd0);
        check("sig_in_fin", sig, fin);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("sig_valid_set", {31'd0, sig_valid}, 32'd1);
        check("sig_final", sig, fin);
    endtask

    initial begin
        logic [31:0] m, prev;
        int a0, d0;

        tbl[0] = '{1,     32'h0,         32'h0,         8'hFF, 1'b0, 1'b1, 32'hFB3EE249};
        tbl[1] = '{0,     32'h0,         32'h0,         8'hFF, 1'b0, 1'b1, 32'hFFFFFFFF};
        tbl[2] = '{3,     32'h12345678,  32'h11111111,  8'hE9, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{8,     32'hA5A5A5A5,  32'h01010101,  8'h55, 1'b0, 1'b0, 32'h0};
        tbl[4] = '{5,     32'h0,         32'h0,         8'hFF, 1'b1, 1'b0, 32'h0};
        tbl[5] = '{2,     32'hFFFFFFFF,  32'h80000001,  8'hB3, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; start = 1'b0; vec_count = 16'd0; resp_valid = 1'b0; resp_data = 32'h0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
        check("rst_ready", {31'd0, resp_ready}, 32'd0);
        check("rst_sig", sig, C_SEED);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run(tbl[k].n, tbl[k].base, tbl[k].step, tbl[k].mask,
                tbl[k].rnd, tbl[k].use_exp, tbl[k].expv);
        end

        // Inputs arriving in IDLE must not disturb the held signature.
        prev = sig;
        for (int k = 0; k < 3; k++) begin
            resp_valid = 1'b1;
            resp_data = $urandom;
            tick();
            check("idle_sig_hold", sig, prev);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_sig_valid", {31'd0, sig_valid}, 32'd1);
        end
        resp_valid = 1'b0;

        // start pulsed in the middle of a run is ignored.
        m = C_SEED;
        start = 1'b1; vec_count = 16'd2; tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 32'hDEADBEEF; m = misr(m, resp_data); tick();
        resp_valid = 1'b0; start = 1'b1; vec_count = 16'd7; prev = sig; tick(); start = 1'b0;
        check("run_start_ignored_sig", sig, prev);
        check("run_start_ignored_busy", {31'd0, busy}, 32'd1);
        resp_valid = 1'b1; resp_data = 32'h0BADF00D; m = misr(m, resp_data);
        sb.push_back(m);
        tick();
        resp_valid = 1'b0;
        check("run_start_done", {31'd0, done}, 32'd1);
        tick();
        check("run_start_sig", sig, m);

        // Reset after 2 of 5 accepts aborts without a done pulse.
        d0 = done_cnt;
        start = 1'b1; vec_count = 16'd5; tick(); start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            resp_valid = 1'b1; resp_data = 32'hC0FFEE00 + 32'h00010203 * k; tick();
        end
        rst_n = 1'b0; start = 1'b1; resp_data = 32'hC0FFEE00 + 32'h00010203 * 2;
        tick();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_sig", sig, C_SEED);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_sig_valid", {31'd0, sig_valid}, 32'd0);
        rst_n = 1'b1; start = 1'b0; resp_valid = 1'b0;
        tick();
        check("midrst_no_done", done_cnt - d0, 32'd0);
        run(5, 32'hC0FFEE00, 32'h00010203, 8'hFF, 1'b0, 1'b0, 32'h0);

        // Maximum-length run.
        a0 = acc_cnt;
        d0 = done_cnt;
        run(65535, 32'h0, 32'h0, 8'hFF, 1'b1, 1'b0, 32'h0);
        check("long_accepts", acc_cnt - a0, 32'd65535);
        check("long_done_pulses", done_cnt - d0, 32'd1);

        tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
